// File: rtl/ddr_types_pkg.sv
// Shared DDR front-end types: request payload and QoS arbiter types.
// Contents: ddr_req_t payload struct, QoS class/weight typedefs, arbiter state enum.
package ddr_types_pkg;

  localparam int unsigned DDR_ADDR_W = 32;
  localparam int unsigned DDR_LEN_W  = 4;
  localparam int unsigned DDR_ID_W   = 4;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic                  write;
    logic [DDR_LEN_W-1:0]  len;
    logic [DDR_ID_W-1:0]   id;
  } ddr_req_t;

  localparam int unsigned QOS_NUM_CLASSES_MAX = 8;
  localparam int unsigned QOS_WEIGHT_W        = 4;

  typedef logic [$clog2(QOS_NUM_CLASSES_MAX)-1:0] qos_class_t;
  typedef logic [QOS_WEIGHT_W-1:0]                qos_weight_t;

  typedef enum logic {
    QOS_IDLE,
    QOS_BURST
  } qos_arb_state_e;

endpackage

// File: rtl/ddr_rr_pick.sv
// Rotating find-first-set: searches mask starting at index start, wrapping
// around, and returns the first set position.
// Ports: mask (N-bit candidates), start (first index examined),
//        found (any bit set), idx (winning index, 0 when none).
module ddr_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // Walk the rotation backwards so the candidate closest to start wins last.
  always_comb begin
    found = |mask;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (mask[pos[IW-1:0]]) begin
        idx = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ddr_qos_wrr_arbiter.sv
// Weighted round-robin QoS arbiter with anti-starvation aging. Each class may
// take up to weight[c] back-to-back grants per turn; a class whose wait age
// reaches age_limit is promoted ahead of WRR order.
// Ports: clk, rst_n; req_valid/req_ready/req per-class request side
//        (req_ready combinational, one-hot or zero); weight per-class burst
//        weights (0 acts as 1); age_limit starvation threshold (0 = off);
//        out_valid/out_ready/out_req/out_class registered downstream side;
//        starve per-class starvation flags.
module ddr_qos_wrr_arbiter
  import ddr_types_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned WEIGHT_W    = QOS_WEIGHT_W,
  parameter int unsigned AGE_W       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CLASSES-1:0]                 req_valid,
  output logic [NUM_CLASSES-1:0]                 req_ready,
  input  ddr_req_t [NUM_CLASSES-1:0]             req,
  input  logic [NUM_CLASSES-1:0][WEIGHT_W-1:0]   weight,
  input  logic [AGE_W-1:0]                       age_limit,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output ddr_req_t                               out_req,
  output logic [$clog2(NUM_CLASSES)-1:0]         out_class,
  output logic [NUM_CLASSES-1:0]                 starve
);

  localparam int unsigned CW = $clog2(NUM_CLASSES);

  qos_arb_state_e        state_q, state_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic [WEIGHT_W-1:0]   budget_q, budget_d;
  logic [CW-1:0]         start_idx;
  logic [CW-1:0]         win;
  logic                  grant;
  logic                  load_en;

  logic [NUM_CLASSES-1:0] aged_mask;
  logic                   aged_found;
  logic [CW-1:0]          aged_idx;
  logic                   valid_found;
  logic [CW-1:0]          valid_idx;

  logic [AGE_W-1:0] age_cnt [NUM_CLASSES];

  // Remaining grants after the first one of a turn; weight 0 behaves as 1.
  function automatic logic [WEIGHT_W-1:0] reload_budget(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? '0 : w - WEIGHT_W'(1);
  endfunction

  // The output register may only be (re)loaded when empty or draining.
  assign load_en   = !out_valid || out_ready;
  assign start_idx = (cur_q == CW'(NUM_CLASSES - 1)) ? '0 : cur_q + CW'(1);
  assign aged_mask = starve & req_valid;

  ddr_rr_pick #(.N(NUM_CLASSES), .IW(CW)) u_pick_aged (
    .mask  (aged_mask),
    .start (start_idx),
    .found (aged_found),
    .idx   (aged_idx)
  );

  // Starting at cur_q+1 makes cur_q itself the last candidate of a new turn.
  ddr_rr_pick #(.N(NUM_CLASSES), .IW(CW)) u_pick_valid (
    .mask  (req_valid),
    .start (start_idx),
    .found (valid_found),
    .idx   (valid_idx)
  );

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= QOS_IDLE;
      cur_q    <= CW'(NUM_CLASSES - 1);
      budget_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      budget_q <= budget_d;
    end
  end

  // Winner selection: aged first, then burst continuation, then a new turn.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    budget_d = budget_q;
    grant    = 1'b0;
    win      = cur_q;
    if (load_en) begin
      if (aged_found) begin
        grant    = 1'b1;
        win      = aged_idx;
        budget_d = reload_budget(weight[aged_idx]);
      end else if (state_q == QOS_BURST && budget_q != '0 && req_valid[cur_q]) begin
        grant    = 1'b1;
        win      = cur_q;
        budget_d = budget_q - WEIGHT_W'(1);
      end else if (valid_found) begin
        // Also covers abandoning a burst whose class dropped its request.
        grant    = 1'b1;
        win      = valid_idx;
        budget_d = reload_budget(weight[valid_idx]);
      end else begin
        budget_d = '0;
      end
      if (grant) begin
        cur_d = win;
      end
      state_d = (budget_d != '0) ? QOS_BURST : QOS_IDLE;
    end
  end

  // Same-cycle accept toward the winning class.
  always_comb begin
    req_ready = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      req_ready[c] = grant && (win == CW'(c));
    end
  end

  // Output register; holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_req   <= '0;
      out_class <= '0;
    end else if (load_en) begin
      out_valid <= grant;
      if (grant) begin
        out_req   <= req[win];
        out_class <= win;
      end
    end
  end

  // Per-class wait age: counts cycles spent valid but not accepted.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_age
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age_cnt[c] <= '0;
      end else if (req_valid[c] && !req_ready[c]) begin
        if (age_cnt[c] != '1) begin
          age_cnt[c] <= age_cnt[c] + AGE_W'(1);
        end
      end else begin
        age_cnt[c] <= '0;
      end
    end

    assign starve[c] = (age_limit != '0) && (age_cnt[c] >= age_limit);
  end

endmodule

// File: tb/tb_ddr_qos_wrr_arbiter.sv
// Self-checking bench for ddr_qos_wrr_arbiter: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_ddr_qos_wrr_arbiter;
  import ddr_types_pkg::*;

  localparam int N      = 4;
  localparam int WW     = 4;
  localparam int AW     = 8;
  localparam int CW     = 2;
  localparam int AGEMAX = (1 << AW) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  ddr_req_t [N-1:0]        req;
  logic [N-1:0][WW-1:0]    weight;
  logic [AW-1:0]           age_limit;
  logic                    out_valid;
  logic                    out_ready;
  ddr_req_t                out_req;
  logic [CW-1:0]           out_class;
  logic [N-1:0]            starve;

  always #5 clk = ~clk;

  ddr_qos_wrr_arbiter #(.NUM_CLASSES(N), .WEIGHT_W(WW), .AGE_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req       (req),
    .weight    (weight),
    .age_limit (age_limit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_req   (out_req),
    .out_class (out_class),
    .starve    (starve)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: current owner, grants left in its turn, wait ages,
  // and the contents of the output register.
  int       m_cur;
  int       m_budget;
  int       m_age [N];
  bit       m_ov;
  ddr_req_t m_oreq;
  int       m_ocls;
  bit       m_load;
  int       m_win;
  bit       m_reload;

  // Expected class order for the fixed-pattern scenarios.
  bit seq_on = 1'b0;
  int seq [8];
  int seq_len = 1;
  int seq_idx = 0;

  task automatic model_reset();
    m_cur    = N - 1;
    m_budget = 0;
    m_ov     = 1'b0;
    m_oreq   = '0;
    m_ocls   = 0;
    for (int c = 0; c < N; c++) m_age[c] = 0;
  endtask

  function automatic bit m_starve(input int c);
    return (age_limit != 0) && (m_age[c] >= int'(age_limit));
  endfunction

  task automatic model_decide();
    m_load   = !m_ov || out_ready;
    m_win    = -1;
    m_reload = 1'b0;
    if (m_load) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_cur + k) % N;
        if (m_win < 0 && req_valid[c] && m_starve(c)) begin
          m_win = c;
          m_reload = 1'b1;
        end
      end
      if (m_win < 0 && m_budget > 0 && req_valid[m_cur]) begin
        m_win = m_cur;
      end
      if (m_win < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c = (m_cur + k) % N;
          if (m_win < 0 && req_valid[c]) begin
            m_win = c;
            m_reload = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int c = 0; c < N; c++) begin
      if (req_valid[c] && m_win != c) m_age[c] = (m_age[c] < AGEMAX) ? m_age[c] + 1 : AGEMAX;
      else m_age[c] = 0;
    end
    if (m_load) begin
      if (m_win >= 0) begin
        m_ov   = 1'b1;
        m_oreq = req[m_win];
        m_ocls = m_win;
        if (m_reload) m_budget = (weight[m_win] == 0) ? 0 : int'(weight[m_win]) - 1;
        else m_budget = m_budget - 1;
        m_cur = m_win;
      end else begin
        m_ov     = 1'b0;
        m_budget = 0;
      end
    end
  endtask

  task automatic rand_payload();
    for (int c = 0; c < N; c++) begin
      req[c].addr  = $urandom;
      req[c].write = 1'($urandom_range(0, 1));
      req[c].len   = 4'($urandom);
      req[c].id    = 4'($urandom);
    end
  endtask

  // One clock: entered and left at posedge+1 with inputs already applied.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_stv;
    rand_payload();
    #2;
    model_decide();
    exp_rdy = '0;
    exp_stv = '0;
    if (m_win >= 0) exp_rdy[m_win] = 1'b1;
    for (int c = 0; c < N; c++) exp_stv[c] = m_starve(c);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("starve", 64'(starve), 64'(exp_stv));
    @(posedge clk);
    model_commit();
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_class", 64'(out_class), 64'(m_ocls));
    check("out_req", 64'(out_req), 64'(m_oreq));
    if (seq_on && out_valid) begin
      check("class_seq", 64'(out_class), 64'(seq[seq_idx % seq_len]));
      seq_idx++;
    end
  endtask

  // Asynchronous reset asserted at posedge+1, released one edge later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_class", 64'(out_class), 64'(0));
    check("rst_out_req", 64'(out_req), 64'(0));
    check("rst_starve", 64'(starve), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    weight[0] = WW'(w0);
    weight[1] = WW'(w1);
    weight[2] = WW'(w2);
    weight[3] = WW'(w3);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    age_limit = '0;
    req       = '0;
    set_weights(1, 1, 1, 1);
    #6;
    do_reset();

    // Equal weights, everyone valid: plain round robin.
    req_valid = '1;
    out_ready = 1'b1;
    seq = '{0, 1, 2, 3, 0, 0, 0, 0};
    seq_len = 4;
    seq_idx = 0;
    seq_on  = 1'b1;
    repeat (20) cycle();
    seq_on = 1'b0;

    // Mixed weights, weight 0 acts as 1.
    do_reset();
    set_weights(3, 1, 0, 2);
    seq = '{0, 0, 0, 1, 2, 3, 3, 0};
    seq_len = 7;
    seq_idx = 0;
    seq_on  = 1'b1;
    repeat (28) cycle();
    seq_on = 1'b0;

    // Single class with downstream stall after the first grant.
    do_reset();
    set_weights(1, 1, 4, 1);
    req_valid = 4'b0100;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (8) cycle();

    // Aging: class 3 overtakes class 0's long burst.
    do_reset();
    set_weights(15, 1, 1, 1);
    age_limit = AW'(6);
    req_valid = 4'b1001;
    repeat (30) cycle();

    // Burst abandonment: class 1 drops out with budget left.
    do_reset();
    age_limit = '0;
    set_weights(1, 4, 1, 1);
    req_valid = 4'b0010;
    cycle();
    cycle();
    req_valid = 4'b1101;
    cycle();
    check("abandon_next", 64'(out_class), 64'(2));
    repeat (6) cycle();

    // Reset in the middle of a burst, then restart from class 0.
    set_weights(3, 2, 2, 2);
    req_valid = '1;
    repeat (2) cycle();
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    do_reset();
    cycle();
    check("first_after_rst", 64'(out_class), 64'(0));

    // Randomized traffic, weights, thresholds and backpressure.
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < N; c++) weight[c] = WW'($urandom);
      age_limit = AW'($urandom_range(0, 12));
      if (seg == 5) do_reset();
      for (int i = 0; i < 200; i++) begin
        for (int c = 0; c < N; c++) req_valid[c] = ($urandom_range(0, 9) < 6);
        out_ready = ($urandom_range(0, 9) < 7);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
